data_ram: RTL and testbench
===========================

# data_ram

Word-organised data memory on the CPU data bus, directly downstream of the multicycle control unit. It consumes `busWe` and the 3-bit `ramControl` size code, and performs byte, half-word and word stores using byte-lane enables. Reads are synchronous, and the loaded value is sign- or zero-extended so that it is valid in the cycle after the address is presented, which is the L_MEM→L_WB step. It also detects misaligned accesses.

## Interface
- `ADDR_WIDTH`, default 8: number of word-address bits; depth is 2^ADDR_WIDTH 32-bit words.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `we`  in  1  store strobe (driven by `busWe`).
- `addr`  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word, [1:0] select the lane. Higher bits are ignored.
- `wdata`  in  32  store data, right-justified.
- `ramControl`  in  3  size/sign code: 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned. Any other value is treated as word.
- `rdata`  out  32  extended load data. Reset value 0.
- `misalign_err`  out  1  one-cycle pulse flagging the previous cycle's misaligned access. Reset value 0.

## Operation
- **Store** (`we`=1, `reset`=1)
  - Writes at the rising edge. Only `ramControl`[1:0] is used; bit 2 is ignored for stores.
  - Byte: lane `addr`[1:0] receives `wdata`[7:0].
  - Half: lanes {`addr`[1],0} and {`addr`[1],1} receive `wdata`[15:0].
  - Word: all four lanes are written.
  - Untouched lanes keep their contents.
- **Read capture** happens every cycle regardless of `we`. Three registers load on each edge:
  - `word_q` ← mem[word addr] (read-first: a same-cycle store to that word yields the old data).
  - `lane_q` ← `addr`[1:0]
  - `ctl_q` ← `ramControl`
- **Extension** is combinational from `word_q`, `lane_q` and `ctl_q`:
  - Byte: selected byte, extended from bit 7 (signed) or zero-extended (unsigned).
  - Half: selected half, extended from bit 15 (signed) or zero-extended (unsigned).
  - Word: passed through unchanged.
- **Misalignment:**
  - Misaligned means a half access with `addr`[0]=1, or a word access with `addr`[1:0]≠00.
  - A misaligned store is suppressed and the memory is unchanged.
  - A misaligned load drives `rdata`=0.
  - In both cases `misalign_err`=1 in the following cycle only.
  - Byte accesses are never misaligned.
- **Address range:** addresses beyond the depth wrap modulo 2^ADDR_WIDTH words. There is no error for out-of-range addresses.

## Timing
- Store latency: data is visible to a read presented in the next cycle; a read in the same cycle sees the old data.
- Load latency: exactly 1 cycle, from `addr`/`ramControl` at edge N to `rdata` valid after edge N.
- Changing `ramControl` between the L_EXE and L_MEM cycles is legal. The value sampled at the last edge governs `rdata`.
- `rdata` is held stable while `addr` and `ramControl` are held stable.
- Reset asserted (`reset`=0) at an edge:
  - Any store in that cycle is suppressed.
  - `word_q`, `lane_q`, `ctl_q` and `misalign_err` clear to 0, so `rdata`=0.
  - Memory contents are preserved.
- There is no handshake and no stall: every access completes in its cycle.

## Configuration
- `DATA_RAM_MISALIGN_CHECK_EN` defined: misalignment detection, store suppression, zeroed load data and `misalign_err` behave as above.
- Undefined:
  - The low address bits are force-aligned: half uses {`addr`[1],0}, word uses 00.
  - Stores and loads proceed on the aligned lanes.
  - `misalign_err` is tied to 0.

## Structure
- The shared package holds:
  - the `ram_ctl_e` enum: RAM_WORD=3'b000, RAM_BYTE=3'b001, RAM_HALF=3'b010, RAM_BYTEU=3'b101, RAM_HALFU=3'b110;
  - the lane-index constants.
- Sub-module `data_ram_load_align`: the purely combinational lane select and extension (`word_q`, `lane_q`, `ctl_q` → `rdata`). It is reused by a future MMIO read path.
- The byte-enable generation and the memory array stay in `data_ram`.

## Test plan
- Word store `addr`=0x10, `wdata`=0xDEADBEEF, `ramControl`=000, then a word load of 0x10 → `rdata`=0xDEADBEEF one cycle later.
- Byte stores of 0x80 to 0x21 and 0x7F to 0x22:
  - lb 0x21 → 0xFFFFFF80;
  - lbu 0x21 → 0x00000080;
  - lb 0x22 → 0x0000007F;
  - other lanes of word 0x20 are unchanged.
- sh 0x8001 to 0x32:
  - lh 0x32 → 0xFFFF8001;
  - lhu 0x32 → 0x00008001;
  - lw 0x30 has the upper half 0x8001 and the lower half unchanged.
- With the check enabled, sw 0x12345678 to 0x41 → memory unchanged and `misalign_err`=1 for one cycle. A following lh 0x43 → `rdata`=0 and another single-cycle `misalign_err` pulse.
- Same-cycle store 0xAAAAAAAA plus read of 0x50 (prior 0x11111111) → `rdata`=0x11111111; the next read gives 0xAAAAAAAA.
- Reset low during a store to 0x60 → word unchanged and `rdata`=0 while in reset. Earlier contents at 0x10 still read 0xDEADBEEF after release.

Source files
------------

// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared size codes, lane constants and alignment helpers for data_ram
package data_ram_pkg;

    typedef enum logic [2:0] {
        RAM_WORD  = 3'b000,
        RAM_BYTE  = 3'b001,
        RAM_HALF  = 3'b010,
        RAM_BYTEU = 3'b101,
        RAM_HALFU = 3'b110
    } ram_ctl_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    // Size comes from the low two bits only; every non-byte/half code is a word.
    function automatic logic is_misaligned(input logic [2:0] ctl, input logic [1:0] lane);
        case (ctl[1:0])
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lane[0];
            default: is_misaligned = (lane != LANE0);
        endcase
    endfunction

    function automatic logic [1:0] align_lane(input logic [2:0] ctl, input logic [1:0] lane);
        case (ctl[1:0])
            SZ_BYTE: align_lane = lane;
            SZ_HALF: align_lane = {lane[1], 1'b0};
            default: align_lane = LANE0;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_load_align.sv
// rtl/data_ram_load_align.sv - combinational lane select and sign/zero extension of a captured word
module data_ram_load_align
    import data_ram_pkg::*;
(
    input  logic [31:0] i_word_q,
    input  logic [1:0]  i_lane_q,
    input  logic [2:0]  i_ctl_q,
    output logic [31:0] o_rdata
);

    logic [1:0]  w_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    always_comb begin
        w_lane     = align_lane(i_ctl_q, i_lane_q);
        w_byte     = i_word_q[{w_lane, 3'b000} +: 8];
        w_half     = w_lane[1] ? i_word_q[31:16] : i_word_q[15:0];
        w_unsigned = (i_ctl_q == RAM_BYTEU) || (i_ctl_q == RAM_HALFU);
        case (i_ctl_q[1:0])
            SZ_BYTE: o_rdata = w_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = w_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_rdata = i_word_q;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// rtl/data_ram.sv - word data memory with lane-enable stores and 1-cycle extended loads; DATA_RAM_MISALIGN_CHECK_EN enables misalignment trapping
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ramControl,
    output logic [31:0] rdata,
    output logic        misalign_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_word_q;
    logic [1:0]  r_lane_q;
    logic [2:0]  r_ctl_q;
    logic        r_mis;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic [1:0]            w_lane_al;
    logic                  w_mis;
    logic                  w_wr;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ext;
    logic                  w_unused_addr;

    assign w_idx         = addr[ADDR_WIDTH+1:2];
    assign w_lane        = addr[1:0];
    assign w_unused_addr = ^addr[31:ADDR_WIDTH+2];

`ifdef DATA_RAM_MISALIGN_CHECK_EN
    assign w_mis = is_misaligned(ramControl, w_lane);
`else
    assign w_mis = 1'b0;
`endif

    // Misaligned stores are suppressed when checking, so aligning the lane is always safe.
    assign w_lane_al = align_lane(ramControl, w_lane);
    assign w_wr      = reset && we && !w_mis;

    always_comb begin
        case (ramControl[1:0])
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_lane_al;
                w_wdata = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be    = w_lane_al[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_wr && w_be[i]) begin
                r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // Read-first capture: same-edge stores are not visible until the following cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word_q <= 32'b0;
            r_lane_q <= LANE0;
            r_ctl_q  <= 3'b0;
            r_mis    <= 1'b0;
        end else begin
            r_word_q <= r_mem[w_idx];
            r_lane_q <= w_lane;
            r_ctl_q  <= ramControl;
            r_mis    <= w_mis;
        end
    end

    data_ram_load_align u_load_align (
        .i_word_q (r_word_q),
        .i_lane_q (r_lane_q),
        .i_ctl_q  (r_ctl_q),
        .o_rdata  (w_ext)
    );

    assign rdata        = r_mis ? 32'b0 : w_ext;
    assign misalign_err = r_mis;

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - self-checking bench for data_ram (vector table, hand sequences, random vs reference model)
module tb_data_ram;

`ifdef DATA_RAM_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ramControl;
    logic [31:0] rdata;
    logic        misalign_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m [256];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctl;
        bit          chk;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    data_ram #(.ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ramControl   (ramControl),
        .rdata        (rdata),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] c);
        case (c[1:0])
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [2:0] c);
        return CHK && ((a % nbytes(c)) != 0);
    endfunction

    function automatic int model_off(input logic [31:0] a, input logic [2:0] c);
        return int'(a % 4) - int'(a % nbytes(c));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
        int          n;
        logic [63:0] v;
        n = nbytes(c);
        if (model_mis(a, c)) return 32'b0;
        v = {32'b0, mem_m[(a / 4) % 256]} >> (8 * model_off(a, c));
        v = v & ((64'd1 << (8 * n)) - 1);
        if (n < 4 && !c[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        int off;
        if (model_mis(a, c)) return;
        off = model_off(a, c);
        for (int b = 0; b < nbytes(c); b++)
            mem_m[(a / 4) % 256][8 * (off + b) +: 8] = d[8 * b +: 8];
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] c, input bit chk, input string nm);
        logic [31:0] exp_d;
        logic        exp_e;
        reset = 1'b1; we = w; addr = a; wdata = d; ramControl = c;
        exp_d = model_load(a, c);
        exp_e = model_mis(a, c);
        if (w) model_store(a, d, c);
        @(posedge clk); #1;
        if (chk) chk32({nm, " rdata"}, rdata, exp_d);
        chk32({nm, " err"}, {31'b0, misalign_err}, {31'b0, exp_e});
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] c, input bit ck, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.ctl = c; v.chk = ck; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        reset = 1'b0; we = 1'b0; addr = 32'b0; wdata = 32'b0; ramControl = 3'b0;
        for (int i = 0; i < 256; i++) mem_m[i] = 32'b0;

        repeat (2) @(posedge clk);
        #1;
        chk32("reset rdata", rdata, 32'b0);
        chk32("reset err", {31'b0, misalign_err}, 32'b0);

        tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 32'h10, 0,            3'b000, 1, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 32'h20, 32'h33221100, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 32'h21, 32'h00000080, 3'b001, 0, 0, 0));
        tbl.push_back(mk(1, 32'h22, 32'h0000007F, 3'b001, 0, 0, 0));
        tbl.push_back(mk(0, 32'h21, 0,            3'b001, 1, 32'hFFFFFF80, 0));
        tbl.push_back(mk(0, 32'h21, 0,            3'b101, 1, 32'h00000080, 0));
        tbl.push_back(mk(0, 32'h22, 0,            3'b001, 1, 32'h0000007F, 0));
        tbl.push_back(mk(0, 32'h20, 0,            3'b000, 1, 32'h337F8000, 0));
        tbl.push_back(mk(1, 32'h30, 32'h55556666, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 32'h32, 32'h00008001, 3'b010, 0, 0, 0));
        tbl.push_back(mk(0, 32'h32, 0,            3'b010, 1, 32'hFFFF8001, 0));
        tbl.push_back(mk(0, 32'h32, 0,            3'b110, 1, 32'h00008001, 0));
        tbl.push_back(mk(0, 32'h30, 0,            3'b000, 1, 32'h80016666, 0));
        tbl.push_back(mk(1, 32'h40, 32'hCAFEF00D, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 32'h41, 32'h12345678, 3'b000, 1, CHK ? 32'h0 : 32'hCAFEF00D, CHK));
        tbl.push_back(mk(0, 32'h40, 0,            3'b000, 1, CHK ? 32'hCAFEF00D : 32'h12345678, 0));
        tbl.push_back(mk(0, 32'h43, 0,            3'b010, 1, CHK ? 32'h0 : 32'h00001234, CHK));
        tbl.push_back(mk(0, 32'h40, 0,            3'b000, 1, CHK ? 32'hCAFEF00D : 32'h12345678, 0));
        tbl.push_back(mk(1, 32'h50, 32'h11111111, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 32'h50, 32'hAAAAAAAA, 3'b000, 1, 32'h11111111, 0));
        tbl.push_back(mk(0, 32'h50, 0,            3'b000, 1, 32'hAAAAAAAA, 0));
        tbl.push_back(mk(0, 32'h410, 0,           3'b000, 1, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 32'hFFFFFC10, 0,      3'b000, 1, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 32'h10, 0,            3'b011, 1, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 32'h10, 0,            3'b100, 1, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 32'h13, 0,            3'b101, 1, 32'h000000DE, 0));
        tbl.push_back(mk(1, 32'h60, 32'h01020304, 3'b000, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = 1'b1; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata; ramControl = tbl[i].ctl;
            if (tbl[i].we) model_store(tbl[i].addr, tbl[i].wdata, tbl[i].ctl);
            @(posedge clk); #1;
            if (tbl[i].chk) chk32($sformatf("row%0d rdata", i), rdata, tbl[i].exp_rdata);
            chk32($sformatf("row%0d err", i), {31'b0, misalign_err}, {31'b0, tbl[i].exp_err});
        end

        // Reset during a store: write suppressed, outputs cleared, memory kept.
        reset = 1'b0; we = 1'b1; addr = 32'h60; wdata = 32'hFFFFFFFF; ramControl = 3'b000;
        @(posedge clk); #1;
        chk32("rst store rdata", rdata, 32'b0);
        chk32("rst store err", {31'b0, misalign_err}, 32'b0);
        addr = 32'h41;
        @(posedge clk); #1;
        chk32("rst misaligned err", {31'b0, misalign_err}, 32'b0);
        step(0, 32'h60, 0, 3'b000, 1, "post rst 0x60");
        chk32("post rst 0x60 value", rdata, 32'h01020304);
        for (int k = 0; k < 3; k++) begin
            step(0, 32'h10, 0, 3'b000, 1, $sformatf("hold 0x10 #%0d", k));
            chk32($sformatf("hold 0x10 value #%0d", k), rdata, 32'hDEADBEEF);
        end

        for (int w = 0; w < 256; w++) step(1, w * 4, $urandom, 3'b000, 0, "init");

        for (int k = 0; k < 800; k++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)), 1,
                 $sformatf("rand%0d", k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
